// File: rtl/add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add_seq_ctrl
//   Sequences a 16*NWORDS-bit add/subtract through an external 16-bit adder,
//   one 16-bit word per clock, least significant word first. The carry out of
//   each word is registered and fed back as the carry-in of the next word.
//   Subtraction is done as A + ~B + 1: B is inverted at capture and the first
//   word gets carry-in = 1.
//
//   NWORDS : operand length in 16-bit words, legal range 1..4.
//
//   Optional feature macro: ADD_SEQ_OVF_EN
//     defined   -> OVF is the registered signed-overflow flag of the result.
//     undefined -> OVF is tied to 0 and no overflow logic is built.
// ---------------------------------------------------------------------------
module add_seq_ctrl #(
  parameter int NWORDS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [16*NWORDS-1:0]   A,
  input  logic [16*NWORDS-1:0]   B,
  output logic [15:0]            add_a,
  output logic [15:0]            add_b,
  output logic                   add_cin,
  input  logic [15:0]            add_s,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [16*NWORDS-1:0]   S,
  output logic                   Cout,
  output logic                   OVF
);

  // Word index width; at least one bit so NWORDS=1 still has a legal vector.
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [NWORDS-1:0][15:0] a_q, a_d;
  logic [NWORDS-1:0][15:0] b_q, b_d;      // effective B (already inverted for sub)
  logic [NWORDS-1:0][15:0] s_q, s_d;
  logic                    sub_q, sub_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;

  logic [15:0]             word_a;
  logic [15:0]             word_b;
  logic                    last_word;

  assign last_word = (k_q == KW'(NWORDS - 1));

  // Select the captured operand words addressed by the word index.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (k_q == KW'(i)) begin
        word_a = a_q[i];
        word_b = b_q[i];
      end
    end
  end

`ifdef ADD_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Next-state, datapath update and adder drive.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          a_d     = A;
          b_d     = sub ? ~B : B;
          sub_d   = sub;
        end
      end

      RUN: begin
        add_a   = word_a;
        add_b   = word_b;
        // The subtract "+1" enters as the carry-in of the first word only.
        add_cin = (k_q == '0) ? sub_q : carry_q;

        for (int i = 0; i < NWORDS; i++) begin
          if (k_q == KW'(i)) s_d[i] = add_s;
        end
        carry_d = add_cout;

        if (last_word) begin
          cout_d  = add_cout;
`ifdef ADD_SEQ_OVF_EN
          // Like-signed operands whose result sign differs have overflowed.
          ovf_d   = (a_q[NWORDS-1][15] == b_q[NWORDS-1][15]) &&
                    (add_s[15] != a_q[NWORDS-1][15]);
`endif
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end

      DONE: begin
        // start is deliberately not looked at here.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: operand and result registers are reset too; the block is small and
  // this keeps every output defined immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef ADD_SEQ_OVF_EN
  // Overflow flag, registered alongside the top result word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add_seq_ctrl
//   Directed bench for add_seq_ctrl. Two instances share clock and reset:
//   dut2 (NWORDS=2) and dut1 (NWORDS=1). Each gets its own behavioural
//   16-bit adder standing in for the external CLA. Inputs change and outputs
//   are sampled on the falling clock edge. Expected values are hand-computed.
//   OVF expectations follow ADD_SEQ_OVF_EN.
// ---------------------------------------------------------------------------
module tb_add_seq_ctrl;

  logic clk;
  logic rst_n;

  // NWORDS=2 instance signals
  logic        start2, sub2;
  logic [31:0] a2, b2;
  logic [15:0] add_a2, add_b2, add_s2;
  logic        add_cin2, add_cout2;
  logic        busy2, done2, cout2, ovf2;
  logic [31:0] s2;

  // NWORDS=1 instance signals
  logic        start1, sub1;
  logic [15:0] a1, b1;
  logic [15:0] add_a1, add_b1, add_s1;
  logic        add_cin1, add_cout1;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] s1;

  int checks   = 0;
  int failures = 0;

  // Per-cycle observation log for one NWORDS=2 operation (cycles 1..4).
  int          busy_cnt, done_cnt, done_at;
  logic        cin_log  [1:4];
  logic [15:0] adda_log [1:4];
  logic [15:0] addb_log [1:4];

`ifdef ADD_SEQ_OVF_EN
  localparam logic OVF_EXP_SAT = 1'b1;
`else
  localparam logic OVF_EXP_SAT = 1'b0;
`endif

  add_seq_ctrl #(.NWORDS(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .sub      (sub2),
    .A        (a2),
    .B        (b2),
    .add_a    (add_a2),
    .add_b    (add_b2),
    .add_cin  (add_cin2),
    .add_s    (add_s2),
    .add_cout (add_cout2),
    .busy     (busy2),
    .done     (done2),
    .S        (s2),
    .Cout     (cout2),
    .OVF      (ovf2)
  );

  add_seq_ctrl #(.NWORDS(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .sub      (sub1),
    .A        (a1),
    .B        (b1),
    .add_a    (add_a1),
    .add_b    (add_b1),
    .add_cin  (add_cin1),
    .add_s    (add_s1),
    .add_cout (add_cout1),
    .busy     (busy1),
    .done     (done1),
    .S        (s1),
    .Cout     (cout1),
    .OVF      (ovf1)
  );

  // External 16-bit adders.
  assign {add_cout2, add_s2} = {1'b0, add_a2} + {1'b0, add_b2} + {16'd0, add_cin2};
  assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {16'd0, add_cin1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the sequence below is fixed-length, this only guards a stall.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launch one NWORDS=2 operation at the current falling edge and observe the
  // four following cycles (RUN, RUN, DONE, IDLE).
  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic s);
    a2 = a; b2 = b; sub2 = s; start2 = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (c == 1) begin
        // Scramble operands after capture; the result must not change.
        a2 = 32'hA5A5_5A5A; b2 = 32'h1234_4321; sub2 = ~s;
      end
      cin_log[c]  = add_cin2;
      adda_log[c] = add_a2;
      addb_log[c] = add_b2;
      if (busy2) busy_cnt++;
      if (done2) begin
        done_cnt++;
        done_at = c;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy2}, 32'd0);
    check("rst_done",  {31'd0, done2}, 32'd0);
    check("rst_S",     s2, 32'd0);
    check("rst_Cout",  {31'd0, cout2}, 32'd0);
    check("rst_OVF",   {31'd0, ovf2}, 32'd0);
    check("rst_add_a", {16'd0, add_a2}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- 0x0000FFFF + 1: carry across words ----------------
    run2(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    check("t1_S",        s2, 32'h0001_0000);
    check("t1_Cout",     {31'd0, cout2}, 32'd0);
    check("t1_done_at",  done_at, 3);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_cnt", busy_cnt, 3);
    check("t1_idle_add_a", {16'd0, adda_log[4]}, 32'd0);

    // ---------------- 0xFFFFFFFF + 1: full wrap ----------------
    run2(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("t2_S",    s2, 32'h0000_0000);
    check("t2_Cout", {31'd0, cout2}, 32'd1);
    check("t2_OVF",  {31'd0, ovf2}, 32'd0);

    // ---------------- 5 - 7: borrow ----------------
    run2(32'h0000_0005, 32'h0000_0007, 1'b1);
    check("t3_cin_first",  {31'd0, cin_log[1]}, 32'd1);
    check("t3_add_a_first", {16'd0, adda_log[1]}, 32'h0000_0005);
    check("t3_add_b_first", {16'd0, addb_log[1]}, 32'h0000_FFF8);
    check("t3_cin_second", {31'd0, cin_log[2]}, 32'd0);
    check("t3_add_b_second", {16'd0, addb_log[2]}, 32'h0000_FFFF);
    check("t3_done_add_a", {16'd0, adda_log[3]}, 32'd0);
    check("t3_done_add_b", {16'd0, addb_log[3]}, 32'd0);
    check("t3_done_cin",   {31'd0, cin_log[3]}, 32'd0);
    check("t3_S",    s2, 32'hFFFF_FFFE);
    check("t3_Cout", {31'd0, cout2}, 32'd0);

    // ---------------- 0x7FFFFFFF + 1: signed overflow ----------------
    run2(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("t4_S",    s2, 32'h8000_0000);
    check("t4_Cout", {31'd0, cout2}, 32'd0);
    check("t4_OVF",  {31'd0, ovf2}, {31'd0, OVF_EXP_SAT});

    // ---------------- reset during the second RUN cycle ----------------
    a2 = 32'h0000_1111; b2 = 32'h0000_2222; sub2 = 1'b0; start2 = 1'b1;
    @(negedge clk);                 // first RUN cycle
    start2 = 1'b0;
    check("t5_busy_run", {31'd0, busy2}, 32'd1);
    @(negedge clk);                 // second RUN cycle
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy",  {31'd0, busy2}, 32'd0);
    check("t5_rst_done",  {31'd0, done2}, 32'd0);
    check("t5_rst_S",     s2, 32'd0);
    check("t5_rst_Cout",  {31'd0, cout2}, 32'd0);
    check("t5_rst_OVF",   {31'd0, ovf2}, 32'd0);
    check("t5_rst_add_a", {16'd0, add_a2}, 32'd0);
    check("t5_rst_add_b", {16'd0, add_b2}, 32'd0);
    check("t5_rst_cin",   {31'd0, add_cin2}, 32'd0);
    @(negedge clk);                 // where the aborted op would have been done
    check("t5_no_done", {31'd0, done2}, 32'd0);
    rst_n = 1'b1;
    // Start together with reset release: accepted at the next rising edge.
    run2(32'h0000_1234, 32'h0001_0001, 1'b0);
    check("t5_post_S",       s2, 32'h0001_1235);
    check("t5_post_Cout",    {31'd0, cout2}, 32'd0);
    check("t5_post_done_at", done_at, 3);
    check("t5_post_done_cnt", done_cnt, 1);

    // ---------------- NWORDS=1: start ignored in RUN and DONE ----------------
    a1 = 16'hFFFF; b1 = 16'h0001; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);                 // RUN
    check("t6_busy_run", {31'd0, busy1}, 32'd1);
    check("t6_done_run", {31'd0, done1}, 32'd0);
    // Hold start high with new operands through RUN and DONE.
    a1 = 16'h0003; b1 = 16'h0001; sub1 = 1'b1; start1 = 1'b1;
    @(negedge clk);                 // DONE
    check("t6_done",  {31'd0, done1}, 32'd1);
    check("t6_S",     {16'd0, s1}, 32'h0000_0000);
    check("t6_Cout",  {31'd0, cout1}, 32'd1);
    @(negedge clk);                 // IDLE: neither start was taken
    check("t6_idle_busy", {31'd0, busy1}, 32'd0);
    check("t6_idle_done", {31'd0, done1}, 32'd0);
    check("t6_hold_S",    {16'd0, s1}, 32'h0000_0000);
    check("t6_hold_Cout", {31'd0, cout1}, 32'd1);
    // start still high: accepted from this IDLE cycle.
    @(negedge clk);                 // RUN
    start1 = 1'b0;
    check("t6_new_busy", {31'd0, busy1}, 32'd1);
    check("t6_new_done_run", {31'd0, done1}, 32'd0);
    @(negedge clk);                 // DONE
    check("t6_new_done", {31'd0, done1}, 32'd1);
    check("t6_new_S",    {16'd0, s1}, 32'h0000_0002);
    check("t6_new_Cout", {31'd0, cout1}, 32'd1);
    @(negedge clk);
    check("t6_new_idle", {31'd0, busy1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
